// File: rtl/mul_div_seq_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer.
//   WORD       : default datapath width
//   md_op_e    : operation encoding presented on the op port
//   md_state_e : sequencer state
package mul_div_seq_pkg;

    localparam int unsigned WORD = 64;

    typedef enum logic [1:0] {
        MD_OP_MUL  = 2'b00,
        MD_OP_SDIV = 2'b01,
        MD_OP_UDIV = 2'b10,
        MD_OP_RSVD = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_CALC,
        MD_FIN
    } md_state_e;

endpackage

// File: rtl/mul_div_seq_iter_core.sv
// Bit-serial datapath shared by multiply and restoring divide.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : capture a (shifting operand) and b (multiplicand / divisor)
//   step       : perform one MSB-first iteration
//   is_div     : selects divide iteration and divide result
//   a, b       : operands captured on load
//   value      : product low half (multiply) or quotient (divide)
module md_iter_core #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] value
);

    // acc: product accumulator, or (WIDTH+1)-bit partial remainder.
    // opnd: multiplier bits shift out of the top; quotient bits shift in at the bottom.
    logic [WIDTH:0]   acc;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] md;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] mul_sum;

    always_comb begin
        shifted = {acc[WIDTH-1:0], opnd[WIDTH-1]};
        trial   = shifted - {1'b0, md};
        // MSB-first shift-add: only the low WIDTH bits are ever needed.
        mul_sum = {acc[WIDTH-2:0], 1'b0} + (opnd[WIDTH-1] ? md : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc  <= '0;
            opnd <= '0;
            md   <= '0;
        end else if (load) begin
            acc  <= '0;
            opnd <= a;
            md   <= b;
        end else if (step) begin
            if (is_div) begin
                // Top bit of trial set means borrow: keep the shifted remainder.
                acc  <= trial[WIDTH] ? shifted : trial;
                opnd <= {opnd[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
                acc  <= {1'b0, mul_sum};
                opnd <= {opnd[WIDTH-2:0], 1'b0};
            end
        end
    end

    assign value = is_div ? opnd : acc[WIDTH-1:0];

endmodule

// File: rtl/mul_div_seq.sv
// Multi-cycle MUL / SDIV / UDIV sequencer with start/busy/done handshake.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, op   : request and operation (00 MUL, 01 SDIV, 10 UDIV, 11 reserved)
//   a, b        : multiplicand/dividend, multiplier/divisor
//   flush       : synchronous abort of the operation in flight
//   busy        : accepted operation in progress
//   done        : one-cycle pulse, result and div_by_zero valid
//   result      : product low half or quotient (held between operations)
//   div_by_zero : divide issued with b == 0
module mul_div_seq
    import mul_div_seq_pkg::*;
#(
    parameter int unsigned WIDTH = WORD,
    parameter int unsigned CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    md_state_e        state;
    md_op_e           op_q;
    md_op_e           op_in;
    logic [CNT_W-1:0] cnt;
    logic             neg_q;
    logic             dz_q;

    logic             accept;
    logic             is_div_in;
    logic             is_div_q;
    logic             dz_in;
    logic [WIDTH-1:0] a_ld;
    logic [WIDTH-1:0] b_ld;
    logic [WIDTH-1:0] core_value;

    always_comb begin
        op_in     = md_op_e'(op);
        is_div_in = (op_in == MD_OP_SDIV) || (op_in == MD_OP_UDIV);
        dz_in     = is_div_in && (b == '0);
        accept    = (state == MD_IDLE) && start && !flush;
        a_ld      = a;
        b_ld      = b;
        if (op_in == MD_OP_SDIV) begin
            // |MIN| wraps to MIN, which is the correct unsigned magnitude.
            a_ld = a[WIDTH-1] ? -a : a;
            b_ld = b[WIDTH-1] ? -b : b;
        end
    end

    assign is_div_q = (op_q == MD_OP_SDIV) || (op_q == MD_OP_UDIV);

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (accept),
        .step   ((state == MD_CALC) && !flush),
        .is_div (is_div_q),
        .a      (a_ld),
        .b      (b_ld),
        .value  (core_value)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= MD_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            op_q        <= MD_OP_MUL;
            neg_q       <= 1'b0;
            dz_q        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                // In IDLE this simply blocks a concurrent start.
                state <= MD_IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    MD_IDLE: begin
                        if (start) begin
                            op_q        <= op_in;
                            neg_q       <= (op_in == MD_OP_SDIV) && (a[WIDTH-1] ^ b[WIDTH-1]);
                            dz_q        <= dz_in;
                            div_by_zero <= 1'b0;
                            busy        <= 1'b1;
                            if (dz_in || (op_in == MD_OP_RSVD)) begin
                                state <= MD_FIN;
                            end else begin
                                state <= MD_CALC;
                                cnt   <= CNT_W'(WIDTH - 1);
                            end
                        end
                    end
                    MD_CALC: begin
                        if (cnt == '0) begin
                            state <= MD_FIN;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    MD_FIN: begin
                        state       <= MD_IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= dz_q;
                        if (dz_q || (op_q == MD_OP_RSVD)) begin
                            result <= '0;
                        end else begin
                            result <= neg_q ? -core_value : core_value;
                        end
                    end
                    default: begin
                        state <= MD_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_seq.sv
// Scoreboard bench for mul_div_seq at WIDTH = 64.
module tb_mul_div_seq;

    localparam int unsigned W = 64;
    localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         div_by_zero;

    mul_div_seq #(
        .WIDTH (W),
        .CNT_W (7)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .flush       (flush),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         dz;
        int unsigned  lat;
        int unsigned  e0;
        string        tag;
    } exp_t;

    exp_t         sb[$];
    exp_t         mon_e;
    int unsigned  cyc = 0;
    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    int unsigned  n_done = 0;
    int unsigned  n_pushed = 0;
    logic [W-1:0] last_res = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        e.res = '0;
        e.dz  = 1'b0;
        e.lat = W + 1;
        e.e0  = 0;
        e.tag = "";
        case (o)
            2'b00: e.res = x * y;
            2'b01: begin
                if (y == '0) begin
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else if (x == MIN_V && y == '1) begin
                    e.res = MIN_V;
                end else begin
                    e.res = $signed(x) / $signed(y);
                end
            end
            2'b10: begin
                if (y == '0) begin
                    e.dz  = 1'b1;
                    e.lat = 1;
                end else begin
                    e.res = x / y;
                end
            end
            default: e.lat = 1;
        endcase
        return e;
    endfunction

    // Drives start for one cycle from a negedge; returns at the negedge after E0.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         input bit push, input string tag);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) begin
            e     = model(o, x, y);
            e.e0  = cyc + 1;
            e.tag = tag;
            sb.push_back(e);
            n_pushed++;
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget, input string tag);
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) return;
        end
        check_eq({"timeout_", tag}, '0, 1);
    endtask

    // Scoreboard consumer.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check_eq("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check_eq({mon_e.tag, "_result"}, result, mon_e.res);
                check_eq({mon_e.tag, "_dz"}, div_by_zero, mon_e.dz);
                check_eq({mon_e.tag, "_latency"}, cyc - mon_e.e0, mon_e.lat);
                last_res = mon_e.res;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_result", result, 0);
        check_eq("rst_dz", div_by_zero, 0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 1, "mul_7_m3");
        check_eq("busy_after_start", busy, 1);
        wait_done(80, "mul_7_m3");
        check_eq("busy_low_at_done", busy, 0);
        @(negedge clk);
        check_eq("done_one_cycle", done, 0);

        issue(2'b01, -64'sd100, 64'd7, 1, "sdiv_m100_7");
        wait_done(80, "sdiv_m100_7");
        @(negedge clk);
        issue(2'b01, MIN_V, '1, 1, "sdiv_min_m1");
        wait_done(80, "sdiv_min_m1");
        @(negedge clk);

        issue(2'b10, '1, 64'd2, 1, "udiv_max_2");
        for (int i = 0; i < 3; i++) begin
            start = 1'b1;
            op    = 2'b00;
            a     = 64'd1;
            b     = 64'd1;
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("busy_during_ignored_start", busy, 1);
        wait_done(80, "udiv_max_2");
        repeat (80) @(negedge clk);
        check_eq("single_done_count", n_done, n_pushed);
        check_eq("result_hold_idle", result, last_res);

        issue(2'b10, 64'd5, 64'd0, 1, "udiv_5_0");
        wait_done(5, "udiv_5_0");
        // Start lands in the same cycle done is high.
        issue(2'b00, 64'd3, 64'd4, 1, "mul_3_4");
        wait_done(80, "mul_3_4");
        @(negedge clk);

        issue(2'b00, 64'd11, 64'd13, 0, "mul_flushed");
        repeat (18) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check_eq("flush_busy", busy, 0);
        repeat (80) @(negedge clk);
        check_eq("flush_no_done", n_done, n_pushed);
        check_eq("flush_result_hold", result, last_res);

        flush = 1'b1;
        start = 1'b1;
        op    = 2'b00;
        a     = 64'd2;
        b     = 64'd2;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check_eq("flush_beats_start", busy, 0);
        issue(2'b00, 64'd6, 64'd6, 1, "mul_6_6");
        wait_done(80, "mul_6_6");
        @(negedge clk);

        issue(2'b01, -64'sd50, 64'd3, 0, "sdiv_reset");
        repeat (28) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        check_eq("midrst_result", result, 0);
        check_eq("midrst_dz", div_by_zero, 0);
        last_res = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (80) @(negedge clk);
        check_eq("midrst_no_done", n_done, n_pushed);
        issue(2'b10, 64'd9, 64'd3, 1, "udiv_9_3");
        wait_done(80, "udiv_9_3");
        @(negedge clk);

        issue(2'b11, 64'd9, 64'd3, 1, "op_rsvd");
        wait_done(5, "op_rsvd");
        @(negedge clk);
        issue(2'b01, 64'd8, 64'd0, 1, "sdiv_8_0");
        wait_done(5, "sdiv_8_0");
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = {$urandom, $urandom};
            rb = (i % 2 == 0) ? {32'd0, $urandom} : {$urandom, $urandom};
            issue(2'(i % 3), ra, rb, 1, $sformatf("rand%0d", i));
            wait_done(80, $sformatf("rand%0d", i));
            @(negedge clk);
        end

        repeat (5) @(negedge clk);
        check_eq("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
